// File: rtl/concurrent_fifo_sync_mc.sv
// Single-clock multi-channel FIFO: NUM_CH logical FIFOs share one storage array,
// one write port and one read port, with per-channel occupancy and threshold flags.
module concurrent_fifo_sync_mc #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned AF_THRESH  = DEPTH - 2,
  parameter  int unsigned AE_THRESH  = 2,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned PW         = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [CH_WIDTH-1:0]   write_ch,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [CH_WIDTH-1:0]   read_ch,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     empty,
  output logic [NUM_CH-1:0]     almost_full,
  output logic [NUM_CH-1:0]     almost_empty,
  output logic [NUM_CH*PW-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0]        mem_q [NUM_CH*DEPTH];
  logic [PW-1:0]                wr_ptr_q [NUM_CH];
  logic [PW-1:0]                wr_ptr_d [NUM_CH];
  logic [PW-1:0]                rd_ptr_q [NUM_CH];
  logic [PW-1:0]                rd_ptr_d [NUM_CH];
  logic [PW-1:0]                cnt [NUM_CH];
  logic [DATA_WIDTH-1:0]        read_data_q;
  logic                         read_valid_q;
  logic                         overflow_q;
  logic                         underflow_q;
  logic                         wr_ok;
  logic                         rd_ok;
  logic [CH_WIDTH+ADDR_WIDTH-1:0] waddr;
  logic [CH_WIDTH+ADDR_WIDTH-1:0] raddr;

  // Flags and occupancy come from registered pointers only.
  always_comb begin
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    count        = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cnt[c]              = wr_ptr_q[c] - rd_ptr_q[c];
      count[c*PW +: PW]   = cnt[c];
      empty[c]            = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]             = (wr_ptr_q[c][PW-1] != rd_ptr_q[c][PW-1]) &&
                            (wr_ptr_q[c][ADDR_WIDTH-1:0] == rd_ptr_q[c][ADDR_WIDTH-1:0]);
      almost_full[c]      = (32'(cnt[c]) >= AF_THRESH);
      almost_empty[c]     = (32'(cnt[c]) <= AE_THRESH);
    end
  end

  always_comb begin
    wr_ok = write_en && (32'(write_ch) < NUM_CH) && !full[write_ch];
    rd_ok = read_en  && (32'(read_ch)  < NUM_CH) && !empty[read_ch];
    waddr = {write_ch, wr_ptr_q[write_ch][ADDR_WIDTH-1:0]};
    raddr = {read_ch,  rd_ptr_q[read_ch][ADDR_WIDTH-1:0]};
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      if (wr_ok && (32'(write_ch) == c)) wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      if (rd_ok && (32'(read_ch)  == c)) rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      if (rd_ok) read_data_q <= mem_q[raddr];
      read_valid_q <= rd_ok;
      overflow_q   <= write_en && !wr_ok;
      underflow_q  <= read_en && !rd_ok;
    end
  end

  // Storage is deliberately unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[waddr] <= write_data;
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_concurrent_fifo_sync_mc.sv
// Directed bench for concurrent_fifo_sync_mc (default parameters: 8-bit, 16 deep, 4 channels).
module tb_concurrent_fifo_sync_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [1:0]  write_ch;
  logic [7:0]  write_data;
  logic        read_en;
  logic [1:0]  read_ch;
  logic [7:0]  read_data;
  logic        read_valid;
  logic [3:0]  full, empty, almost_full, almost_empty;
  logic [19:0] count;
  logic        overflow, underflow;

  int n_assert = 0;
  int n_fail   = 0;
  int wn, rn;

  concurrent_fifo_sync_mc #(
    .DATA_WIDTH(8), .DEPTH(16), .NUM_CH(4), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .write_en(write_en), .write_ch(write_ch), .write_data(write_data),
    .read_en(read_en), .read_ch(read_ch),
    .read_data(read_data), .read_valid(read_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] cnt_of(input int c);
    return count[c*5 +: 5];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".read_data"},    32'(read_data),    32'h0);
    chk({tag, ".read_valid"},   32'(read_valid),   32'h0);
    chk({tag, ".overflow"},     32'(overflow),     32'h0);
    chk({tag, ".underflow"},    32'(underflow),    32'h0);
    chk({tag, ".full"},         32'(full),         32'h0);
    chk({tag, ".empty"},        32'(empty),        32'hF);
    chk({tag, ".count"},        32'(count),        32'h0);
    chk({tag, ".almost_full"},  32'(almost_full),  32'h0);
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'hF);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                       input logic re, input logic [1:0] rc);
    write_en = we; write_ch = wc; write_data = wd; read_en = re; read_ch = rc;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    #3;
    chk_reset("por");
    #5 reset = 1'b1;
    cyc();

    // Single channel ordering on ch 2
    drive(1, 2, 8'hA1, 0, 0); cyc();
    chk("t1.cnt1", 32'(cnt_of(2)), 1);
    chk("t1.empty2", 32'(empty[2]), 0);
    drive(1, 2, 8'hB2, 0, 0); cyc();
    chk("t1.cnt2", 32'(cnt_of(2)), 2);
    drive(0, 0, 0, 1, 2); cyc();
    chk("t1.rv1", 32'(read_valid), 1);
    chk("t1.rd1", 32'(read_data), 32'hA1);
    chk("t1.cnt3", 32'(cnt_of(2)), 1);
    cyc();
    chk("t1.rv2", 32'(read_valid), 1);
    chk("t1.rd2", 32'(read_data), 32'hB2);
    chk("t1.cnt4", 32'(cnt_of(2)), 0);
    chk("t1.empty2b", 32'(empty[2]), 1);
    drive(0, 0, 0, 0, 0); cyc();
    chk("t1.rv_off", 32'(read_valid), 0);
    chk("t1.rd_hold", 32'(read_data), 32'hB2);

    // Fill ch 0 to full, then overflow
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i), 0, 0); cyc();
      chk("t2.cnt", 32'(cnt_of(0)), 32'(i + 1));
      chk("t2.af", 32'(almost_full[0]), 32'((i + 1) >= 14));
      chk("t2.ae", 32'(almost_empty[0]), 32'((i + 1) <= 2));
      chk("t2.full", 32'(full[0]), 32'((i + 1) == 16));
    end
    drive(1, 0, 8'hFF, 0, 0); cyc();
    chk("t2.ovf", 32'(overflow), 1);
    chk("t2.cnt_ovf", 32'(cnt_of(0)), 16);
    chk("t2.others_empty", 32'(empty), 32'hE);
    chk("t2.full_vec", 32'(full), 32'h1);
    drive(0, 0, 0, 0, 0); cyc();
    chk("t2.ovf_pulse", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 0); cyc();
      chk("t2.drain_rv", 32'(read_valid), 1);
      chk("t2.drain_rd", 32'(read_data), 32'(i));
    end
    chk("t2.drained", 32'(empty[0]), 1);

    // Simultaneous write+read on ch 1 at count 5
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 8'(8'h10 + i), 0, 0); cyc();
    end
    chk("t3.cnt5", 32'(cnt_of(1)), 5);
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 8'(8'h15 + k), 1, 1); cyc();
      chk("t3.cnt_hold", 32'(cnt_of(1)), 5);
      chk("t3.rv", 32'(read_valid), 1);
      chk("t3.rd", 32'(read_data), 32'(8'h10 + k));
    end
    for (int k = 0; k < 11; k++) begin
      drive(1, 1, 8'(8'h29 + k), 0, 0); cyc();
    end
    chk("t3.full1", 32'(full[1]), 1);
    chk("t3.af1", 32'(almost_full[1]), 1);
    drive(1, 1, 8'hEE, 1, 1); cyc();
    chk("t3.full_ovf", 32'(overflow), 1);
    chk("t3.full_rv", 32'(read_valid), 1);
    chk("t3.full_rd", 32'(read_data), 32'h24);
    chk("t3.full_cnt", 32'(cnt_of(1)), 15);
    chk("t3.full_clr", 32'(full[1]), 0);

    // Read empty ch 3 with concurrent write: no bypass
    drive(1, 3, 8'h77, 1, 3); cyc();
    chk("t4.udf", 32'(underflow), 1);
    chk("t4.rv", 32'(read_valid), 0);
    chk("t4.cnt", 32'(cnt_of(3)), 1);
    chk("t4.ovf", 32'(overflow), 0);
    drive(0, 0, 0, 1, 3); cyc();
    chk("t4.rd", 32'(read_data), 32'h77);
    chk("t4.rv2", 32'(read_valid), 1);
    chk("t4.udf2", 32'(underflow), 0);
    chk("t4.cnt2", 32'(cnt_of(3)), 0);

    // Pointer wrap on ch 0 (pointers start at 16, cross 32)
    wn = 0; rn = 0;
    for (int t = 0; t < 42; t++) begin
      drive(t < 40, 0, 8'(8'h40 + t), t >= 2, 0); cyc();
      if (t < 40) wn++;
      if (t >= 2) begin
        rn++;
        chk("t5.rv", 32'(read_valid), 1);
        chk("t5.rd", 32'(read_data), 32'(8'h40 + rn - 1));
      end
      chk("t5.cnt", 32'(cnt_of(0)), 32'(wn - rn));
      chk("t5.empty", 32'(empty[0]), 32'(wn == rn));
      chk("t5.full", 32'(full[0]), 0);
    end

    // Interleaved traffic, then asynchronous reset mid-burst
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'(k), 8'(8'h80 + k), 1, 1); cyc();
      chk("t6.rv", 32'(read_valid), 1);
      chk("t6.rd", 32'(read_data), 32'(8'h25 + k));
    end
    #1 reset = 1'b0;
    #1;
    chk_reset("midrst");
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #4 reset = 1'b1;
    cyc();
    chk("t6.post_empty", 32'(empty), 32'hF);
    chk("t6.post_cnt", 32'(count), 0);
    drive(1, 2, 8'h5A, 0, 0); cyc();
    chk("t6.new_cnt", 32'(cnt_of(2)), 1);
    drive(0, 0, 0, 1, 2); cyc();
    chk("t6.new_rv", 32'(read_valid), 1);
    chk("t6.new_rd", 32'(read_data), 32'h5A);
    chk("t6.new_empty", 32'(empty), 32'hF);
    drive(0, 0, 0, 0, 0); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
